mac_feeder: RTL and testbench
=============================

Name: mac_feeder

Overview:
- Drives the MAC operand interface (in_valid, in1_IFM, in2_IFM) and collects its result (out_valid, out).
- Buffers operand pairs written by a host, issues them to the MAC as fixed-length bursts, and waits for each result.
- Returns each result to the host through a ready/valid port.
- Sits between the host/control logic and the MAC, replacing the bench-only stimulus source in synthesizable designs.

Parameters:
- DATA_W, 4, operand width (matches in1_IFM/in2_IFM).
- OUT_W, 10, MAC result width.
- BURST_LEN, 4, operand pairs per MAC transaction; requires BURST_LEN*(2^DATA_W-1)^2 < 2^OUT_W.
- FIFO_DEPTH, 8, operand-pair buffer depth; power of 2, at least BURST_LEN.
- TIMEOUT, 64, cycles to wait for out_valid after the last pair before declaring an error.

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  host presents an operand pair.
- wr_a  in  DATA_W  operand a.
- wr_b  in  DATA_W  operand b.
- wr_ready  out  1  FIFO not full.
- mac_in_valid  out  1  to MAC in_valid.
- mac_in1  out  DATA_W  to MAC in1_IFM.
- mac_in2  out  DATA_W  to MAC in2_IFM.
- mac_out_valid  in  1  from MAC out_valid.
- mac_out  in  OUT_W  from MAC out.
- res_valid  out  1  result available.
- res_data  out  OUT_W  result value.
- res_ready  in  1  host accepts result.
- busy  out  1  state is not IDLE.
- err_timeout  out  1  one-cycle pulse on timeout.
- err_early  out  1  one-cycle pulse when mac_out_valid is seen while in SEND.

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high. On the cycle rst is sampled high:
  - FIFO is emptied, state goes to IDLE, all counters clear.
  - All outputs go to 0, except wr_ready=1.
  - Applies mid-burst too: mac_in_valid is 0 in the first cycle after reset. Any MAC result still in flight is ignored.
- FIFO:
  - A write occurs when wr_valid&&wr_ready.
  - wr_ready = (count != FIFO_DEPTH), registered from count.
  - Pointers wrap modulo FIFO_DEPTH.
  - A simultaneous write and pop at full is not allowed, because wr_ready=0 when full.
  - A simultaneous write and pop otherwise leaves count unchanged.
- State machine: IDLE, SEND, WAIT, HOLD.
  - IDLE -> SEND when count >= BURST_LEN and res_valid=0.
  - SEND:
    - Pops one pair per cycle, registered onto mac_in1/mac_in2 with mac_in_valid=1.
    - Exactly BURST_LEN consecutive cycles, no gaps.
    - beat counter runs 0..BURST_LEN-1.
    - After the last beat -> WAIT, with mac_in_valid=0 and the operand outputs held at 0.
  - WAIT:
    - Timeout counter increments each cycle.
    - If mac_out_valid=1: capture mac_out into res_data, set res_valid=1, go to HOLD.
    - If the counter reaches TIMEOUT-1 without mac_out_valid: pulse err_timeout, go to IDLE, no result produced.
  - HOLD:
    - res_valid stays high and res_data stays stable until res_ready=1.
    - On the handshake cycle, res_valid drops next cycle and the state returns to IDLE.
    - A new burst may start the cycle after that if FIFO count allows.
- mac_out_valid in SEND: pulse err_early, ignore the value, continue the burst.
- mac_out_valid in IDLE or HOLD: ignored silently.
- Latency: first mac_in_valid one cycle after the IDLE->SEND decision. res_valid one cycle after mac_out_valid is sampled in WAIT.
- Arithmetic: the feeder does no arithmetic on the data path; mac_out passes through unsigned.
- Writes are accepted in every state, including during SEND, as long as the FIFO is not full.

Optional Feature:
- Macro: MAC_FEEDER_CHECK_EN.
- Defined:
  - During SEND, accumulates the unsigned sum of mac_in1*mac_in2 (OUT_W bits) for the current burst.
  - In WAIT, on mac_out_valid, compares the accumulated sum with mac_out.
  - Adds output port chk_mismatch (1 bit). It is high together with res_valid when the values differ, held while in HOLD, and 0 otherwise.
  - The accumulator clears on reset and at each IDLE->SEND transition.
- Undefined: no accumulator, no chk_mismatch port; behaviour is otherwise identical.

Decomposition:
- Shared package mac_pkg holds:
  - the state enum (IDLE/SEND/WAIT/HOLD);
  - default constants MAC_DATA_W=4, MAC_OUT_W=10, MAC_BURST_LEN=4.
- One sub-module: mac_feeder_fifo, a synchronous FIFO of {a,b} pairs with count output, reset by rst.
- FSM, counters and result register are in mac_feeder.

Test Plan:
1. Reset, then write 4 pairs (3,5),(2,7),(15,15),(0,9) -> mac_in_valid high for 4 consecutive cycles with those operands in order. A bench MAC model returns 254 -> res_valid=1, res_data=254, held until res_ready. With MAC_FEEDER_CHECK_EN, chk_mismatch=0.
2. Write 8 pairs back-to-back -> wr_ready=0 after the 8th write. Two bursts are issued, the second only after the first result is accepted; two results come back in order.
3. MAC model never asserts out_valid -> err_timeout pulses exactly 64 cycles after the last beat, state returns to IDLE, res_valid stays 0.
4. MAC model asserts out_valid during beat 2 -> err_early pulses once and the burst completes its 4 beats. With MAC_FEEDER_CHECK_EN, a wrong returned value (e.g. 253 vs 254) -> chk_mismatch=1.
5. Assert rst during beat 2 of SEND -> next cycle mac_in_valid=0, busy=0, wr_ready=1, FIFO empty. The late MAC out_valid is ignored and res_valid stays 0.
6. res_ready held low for 10 cycles in HOLD with 4 more pairs queued -> no new burst starts until the handshake; res_data is stable throughout.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared state encoding and default widths for the MAC feeder.
// Imported by the feeder interface, FIFO and top.
package mac_pkg;

    localparam int MAC_DATA_W    = 4;
    localparam int MAC_OUT_W     = 10;
    localparam int MAC_BURST_LEN = 4;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        HOLD
    } state_e;

endpackage

// File: rtl/mac_feeder_if.sv
// mac_feeder_if: host write port, MAC operand/result port and host result port.
// slave is the feeder's view; master is the host+MAC view.
interface mac_feeder_if
    import mac_pkg::*;
#(
    parameter int DATA_W = MAC_DATA_W,
    parameter int OUT_W  = MAC_OUT_W
);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_a;
    logic [DATA_W-1:0] wr_b;
    logic              wr_ready;
    logic              mac_in_valid;
    logic [DATA_W-1:0] mac_in1;
    logic [DATA_W-1:0] mac_in2;
    logic              mac_out_valid;
    logic [OUT_W-1:0]  mac_out;
    logic              res_valid;
    logic [OUT_W-1:0]  res_data;
    logic              res_ready;

    modport slave (
        input  wr_valid, wr_a, wr_b,
        output wr_ready,
        output mac_in_valid, mac_in1, mac_in2,
        input  mac_out_valid, mac_out,
        output res_valid, res_data,
        input  res_ready
    );

    modport master (
        output wr_valid, wr_a, wr_b,
        input  wr_ready,
        input  mac_in_valid, mac_in1, mac_in2,
        output mac_out_valid, mac_out,
        input  res_valid, res_data,
        output res_ready
    );
endinterface

// File: rtl/mac_feeder_fifo.sv
// mac_feeder_fifo: synchronous FIFO of {a,b} operand pairs with occupancy count.
// not_full is registered so wr_ready never depends combinationally on pop.
module mac_feeder_fifo
    import mac_pkg::*;
#(
    parameter int W     = 2 * MAC_DATA_W,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     not_full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          not_full_q, not_full_d;
    logic          push;

    assign push = wr_en && not_full_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        not_full_d = (count_d != (AW+1)'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            not_full_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            not_full_q <= not_full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout     = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign not_full = not_full_q;
endmodule

// File: rtl/mac_feeder.sv
// mac_feeder: buffers host operand pairs, issues BURST_LEN-beat MAC bursts, returns results.
// Define MAC_FEEDER_CHECK_EN to cross-check each MAC result against a local sum of products.
module mac_feeder
    import mac_pkg::*;
#(
    parameter int DATA_W     = MAC_DATA_W,
    parameter int OUT_W      = MAC_OUT_W,
    parameter int BURST_LEN  = MAC_BURST_LEN,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst,
    mac_feeder_if.slave bus,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_early
`ifdef MAC_FEEDER_CHECK_EN
    ,
    output logic        chk_mismatch
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT);

    state_e            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              mac_in_valid_q, mac_in_valid_d;
    logic [DATA_W-1:0] mac_in1_q, mac_in1_d;
    logic [DATA_W-1:0] mac_in2_q, mac_in2_d;
    logic              res_valid_q, res_valid_d;
    logic [OUT_W-1:0]  res_data_q, res_data_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_early_q, err_early_d;
    logic              pop;
    logic [2*DATA_W-1:0] head;
    logic [CW-1:0]     count;
    logic              wr_ready;
`ifdef MAC_FEEDER_CHECK_EN
    logic [OUT_W-1:0]  acc_q, acc_d;
    logic              chk_q, chk_d;
`endif

    mac_feeder_fifo #(
        .W     (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (bus.wr_valid),
        .din      ({bus.wr_a, bus.wr_b}),
        .pop      (pop),
        .dout     (head),
        .count    (count),
        .not_full (wr_ready)
    );

    // Pairs are popped on the cycle whose next state is SEND, so the
    // registered operands line up exactly with the SEND cycles.
    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        tmo_d          = tmo_q;
        mac_in_valid_d = 1'b0;
        mac_in1_d      = '0;
        mac_in2_d      = '0;
        res_valid_d    = res_valid_q;
        res_data_d     = res_data_q;
        err_timeout_d  = 1'b0;
        err_early_d    = 1'b0;
        pop            = 1'b0;
`ifdef MAC_FEEDER_CHECK_EN
        acc_d          = acc_q;
        chk_d          = chk_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (count >= CW'(BURST_LEN) && !res_valid_q) begin
                    state_d = SEND;
                    beat_d  = '0;
                    pop     = 1'b1;
`ifdef MAC_FEEDER_CHECK_EN
                    acc_d   = '0;
`endif
                end
            end
            SEND: begin
                err_early_d = bus.mac_out_valid;
`ifdef MAC_FEEDER_CHECK_EN
                acc_d = acc_q + OUT_W'(mac_in1_q) * OUT_W'(mac_in2_q);
`endif
                if (beat_q == BW'(BURST_LEN - 1)) begin
                    state_d = WAIT;
                    tmo_d   = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                    pop    = 1'b1;
                end
            end
            WAIT: begin
                if (bus.mac_out_valid) begin
                    state_d     = HOLD;
                    res_valid_d = 1'b1;
                    res_data_d  = bus.mac_out;
`ifdef MAC_FEEDER_CHECK_EN
                    chk_d       = (acc_q != bus.mac_out);
`endif
                end else if (tmo_q == TW'(TIMEOUT - 2)) begin
                    state_d       = IDLE;
                    err_timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            HOLD: begin
                if (bus.res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
`ifdef MAC_FEEDER_CHECK_EN
                    chk_d       = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            mac_in_valid_d = 1'b1;
            mac_in1_d      = head[2*DATA_W-1:DATA_W];
            mac_in2_d      = head[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            beat_q         <= '0;
            tmo_q          <= '0;
            mac_in_valid_q <= 1'b0;
            mac_in1_q      <= '0;
            mac_in2_q      <= '0;
            res_valid_q    <= 1'b0;
            res_data_q     <= '0;
            err_timeout_q  <= 1'b0;
            err_early_q    <= 1'b0;
`ifdef MAC_FEEDER_CHECK_EN
            acc_q          <= '0;
            chk_q          <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            tmo_q          <= tmo_d;
            mac_in_valid_q <= mac_in_valid_d;
            mac_in1_q      <= mac_in1_d;
            mac_in2_q      <= mac_in2_d;
            res_valid_q    <= res_valid_d;
            res_data_q     <= res_data_d;
            err_timeout_q  <= err_timeout_d;
            err_early_q    <= err_early_d;
`ifdef MAC_FEEDER_CHECK_EN
            acc_q          <= acc_d;
            chk_q          <= chk_d;
`endif
        end
    end

    assign bus.wr_ready     = wr_ready;
    assign bus.mac_in_valid = mac_in_valid_q;
    assign bus.mac_in1      = mac_in1_q;
    assign bus.mac_in2      = mac_in2_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_data     = res_data_q;
    assign busy             = (state_q != IDLE);
    assign err_timeout      = err_timeout_q;
    assign err_early        = err_early_q;
`ifdef MAC_FEEDER_CHECK_EN
    assign chk_mismatch     = chk_q;
`endif
endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: directed stimulus with operand/result scoreboards and a behavioural MAC.
// Build with MAC_FEEDER_CHECK_EN to also score chk_mismatch.
module tb_mac_feeder;
    import mac_pkg::*;

    localparam int DW = MAC_DATA_W;
    localparam int OW = MAC_OUT_W;

    typedef struct {
        int data;
        bit chk;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic err_timeout;
    logic err_early;
`ifdef MAC_FEEDER_CHECK_EN
    logic chk_mismatch;
`endif

    mac_feeder_if #(.DATA_W(DW), .OUT_W(OW)) bus ();

    mac_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_early    (err_early)
`ifdef MAC_FEEDER_CHECK_EN
        ,
        .chk_mismatch (chk_mismatch)
`endif
    );

    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_chk  = 0;
    int   cyc    = 0;
    int   exp_ops[$];
    res_t exp_res[$];
    int   mode = 0;   // 0 normal, 1 silent, 2 early pulse + late result
    int   bias = 0;
    int   last_beat_cyc = 0;
    int   tmo_cyc = 0;
    int   tmo_busy = 1;
    int   early_cnt = 0;
    int   tmo_cnt = 0;
    int   rv_seen = 0;
    int   overlap = 0;
    int   run = 0;
    int   last_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic push(input int a, input int b);
        int k = 0;
        while (!bus.wr_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("push_wr_ready", int'(bus.wr_ready), 1);
        bus.wr_valid = 1'b1;
        bus.wr_a     = DW'(a);
        bus.wr_b     = DW'(b);
        exp_ops.push_back(a * 16 + b);
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
    endtask

    task automatic push_res(input int d, input bit c);
        res_t r;
        r.data = d;
        r.chk  = c;
        exp_res.push_back(r);
    endtask

    task automatic wait_rv(input int n, input string nm);
        int k = 0;
        while (rv_seen < n && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        check(nm, rv_seen, n);
    endtask

    // Behavioural MAC: sums the burst and answers a few cycles after in_valid drops.
    initial begin : mac_model
        int acc;
        int beats;
        int dly;
        bit prev;
        acc = 0; beats = 0; dly = 0; prev = 1'b0;
        bus.mac_out_valid = 1'b0;
        bus.mac_out = '0;
        forever begin
            @(negedge clk);
            bus.mac_out_valid = 1'b0;
            if (bus.mac_in_valid) begin
                acc += int'(bus.mac_in1) * int'(bus.mac_in2);
                beats++;
                if (mode == 2 && beats == 3) begin
                    bus.mac_out_valid = 1'b1;
                    bus.mac_out = OW'(999);
                end
            end else if (prev) begin
                dly = 3;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    if (mode != 1) begin
                        bus.mac_out_valid = 1'b1;
                        bus.mac_out = OW'(acc + bias);
                    end
                    acc = 0;
                    beats = 0;
                end
            end
            prev = bus.mac_in_valid;
        end
    end

    always @(negedge clk) begin : mon
        int   e;
        res_t r;
        if (!rst) begin
            if (bus.mac_in_valid) begin
                last_beat_cyc = cyc;
                run++;
                if (bus.res_valid) overlap++;
                check("op_queue_level", int'(exp_ops.size() > 0), 1);
                if (exp_ops.size() > 0) begin
                    e = exp_ops.pop_front();
                    check("op_a", int'(bus.mac_in1), e / 16);
                    check("op_b", int'(bus.mac_in2), e % 16);
                end
            end else if (run > 0) begin
                last_run = run;
                run = 0;
            end
            if (err_early) early_cnt++;
            if (err_timeout) begin
                tmo_cnt++;
                tmo_cyc  = cyc;
                tmo_busy = int'(busy);
            end
            if (bus.res_valid && bus.res_ready) begin
                check("res_queue_level", int'(exp_res.size() > 0), 1);
                if (exp_res.size() > 0) begin
                    r = exp_res.pop_front();
                    check("res_data", int'(bus.res_data), r.data);
`ifdef MAC_FEEDER_CHECK_EN
                    check("chk_mismatch", int'(chk_mismatch), int'(r.chk));
`endif
                end
                rv_seen++;
            end
        end else begin
            run = 0;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int k;
        int hold_bad;
        int mv_bad;
        int rv_cyc;
        int base;
        int rv_base;
        rst = 1'b1;
        bus.wr_valid  = 1'b0;
        bus.wr_a      = '0;
        bus.wr_b      = '0;
        bus.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_ready", int'(bus.wr_ready), 1);
        check("rst_mac_in_valid", int'(bus.mac_in_valid), 0);
        check("rst_res_valid", int'(bus.res_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err_timeout", int'(err_timeout), 0);
        check("rst_err_early", int'(err_early), 0);
        rst = 1'b0;

        // 1: basic burst, result held while res_ready low
        bus.res_ready = 1'b0;
        push_res(254, 1'b0);
        push(3, 5); push(2, 7); push(15, 15); push(0, 9);
        k = 0;
        while (!bus.res_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("t1_res_valid", int'(bus.res_valid), 1);
        check("t1_res_data", int'(bus.res_data), 254);
        check("t1_burst_len", last_run, 4);
`ifdef MAC_FEEDER_CHECK_EN
        check("t1_chk", int'(chk_mismatch), 0);
`endif

        // 2+6: fill FIFO during HOLD, nothing issues until handshake
        push_res(30, 1'b0);
        push_res(174, 1'b0);
        push(1, 1); push(2, 2); push(3, 3); push(4, 4);
        push(5, 5); push(6, 6); push(7, 7); push(8, 8);
        check("t2_wr_ready_full", int'(bus.wr_ready), 0);
        hold_bad = 0;
        mv_bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.res_data != OW'(254) || !bus.res_valid) hold_bad++;
            if (bus.mac_in_valid) mv_bad++;
        end
        check("t6_res_stable", hold_bad, 0);
        check("t6_no_burst", mv_bad, 0);
        bus.res_ready = 1'b1;
        wait_rv(3, "t2_results");
        check("t2_burst_len", last_run, 4);
        check("t2_wr_ready", int'(bus.wr_ready), 1);

        // 3: MAC never answers
        mode = 1;
        base = tmo_cnt;
        rv_base = rv_seen;
        push(1, 2); push(3, 4); push(5, 6); push(7, 8);
        k = 0;
        while (tmo_cnt == base && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (5) @(posedge clk);
        #1;
        check("t3_tmo_pulses", tmo_cnt - base, 1);
        check("t3_tmo_delay", tmo_cyc - last_beat_cyc, 64);
        check("t3_busy_at_tmo", tmo_busy, 0);
        check("t3_burst_len", last_run, 4);
        check("t3_no_result", rv_seen, rv_base);
        check("t3_res_valid", int'(bus.res_valid), 0);
        check("t3_busy", int'(busy), 0);

        // 4: early out_valid during beat 2, wrong final value
        mode = 2;
        bias = -1;
        base = early_cnt;
        push_res(253, 1'b1);
        push(3, 5); push(2, 7); push(15, 15); push(0, 9);
        wait_rv(rv_base + 1, "t4_result");
        check("t4_early_pulses", early_cnt - base, 1);
        check("t4_burst_len", last_run, 4);
        mode = 0;
        bias = 0;

        // 5: reset in beat 2, late MAC answer ignored, FIFO emptied
        push(1, 3); push(2, 3); push(3, 3); push(4, 3);
        k = 0;
        mv_bad = 0;
        while (mv_bad < 3 && k < 100) begin
            @(posedge clk); #1;
            k++;
            if (bus.mac_in_valid) mv_bad++;
        end
        check("t5_reached_beat2", mv_bad, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5_mac_in_valid", int'(bus.mac_in_valid), 0);
        check("t5_mac_in1", int'(bus.mac_in1), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_wr_ready", int'(bus.wr_ready), 1);
        check("t5_res_valid", int'(bus.res_valid), 0);
        rst = 1'b0;
        exp_ops.delete();
        rv_base = rv_seen;
        push(1, 2); push(3, 4); push(5, 6);
        mv_bad = 0;
        rv_cyc = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.mac_in_valid) mv_bad++;
            if (bus.res_valid) rv_cyc++;
        end
        check("t5_fifo_emptied", mv_bad, 0);
        check("t5_late_ignored", rv_cyc, 0);
        push_res(100, 1'b0);
        push(7, 8);
        wait_rv(rv_base + 1, "t5_result");

        check("no_overlap", overlap, 0);
        check("ops_drained", exp_ops.size(), 0);
        check("res_drained", exp_res.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
